// File: rtl/pipeline_wb_arb.sv
// Write-back stage: one-hot source mux for the in-order result, arbitrated against a
// late-result FIFO for the single register-file write port.
module pipeline_wb_arb #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_SRC    = 5,
    parameter int unsigned LATE_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              valid_m_i,
    input  logic                              reg_write_en_m_i,
    input  logic [4:0]                        rd_idx_m_i,
    input  logic [NUM_SRC-1:0]                result_src_m_i,
    input  logic [NUM_SRC*XLEN-1:0]           src_data_m_i,
    output logic                              stall_m_o,
    input  logic                              late_valid_i,
    output logic                              late_ready_o,
    input  logic [4:0]                        late_rd_idx_i,
    input  logic [XLEN-1:0]                   late_data_i,
    output logic [$clog2(LATE_DEPTH+1)-1:0]   late_pending_o,
    output logic                              reg_write_en_w_o,
    output logic [4:0]                        rd_idx_w_o,
    output logic [XLEN-1:0]                   write_back_data_w_o
);

    localparam int unsigned PtrW = $clog2(LATE_DEPTH);
    localparam int unsigned CntW = $clog2(LATE_DEPTH + 1);

    logic [XLEN-1:0] mux_data;
    logic            ireq;
    logic            full;
    logic            push;
    logic            pop;
    logic            take_inorder;

    logic [CntW-1:0] count_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [4:0]      fifo_rd_q   [LATE_DEPTH];
    logic [XLEN-1:0] fifo_data_q [LATE_DEPTH];

    // AND-OR mux: zero-hot gives 0, multi-hot ORs the selected sources.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            mux_data = mux_data | (src_data_m_i[k*XLEN +: XLEN] & {XLEN{result_src_m_i[k]}});
        end
    end

    assign ireq         = valid_m_i & reg_write_en_m_i & (rd_idx_m_i != 5'd0);
    assign full         = (count_q == CntW'(LATE_DEPTH));
    assign late_ready_o = ~full;
    // rd = 0 late results complete the handshake but are dropped here.
    assign push         = late_valid_i & late_ready_o & (late_rd_idx_i != 5'd0);
    assign pop          = full | (~ireq & (count_q != '0));
    assign take_inorder = ireq & ~full;
    assign stall_m_o    = ireq & full;

    assign late_pending_o = count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q <= count_q + CntW'(push) - CntW'(pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= late_rd_idx_i;
            fifo_data_q[wr_ptr_q] <= late_data_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reg_write_en_w_o    <= 1'b0;
            rd_idx_w_o          <= 5'd0;
            write_back_data_w_o <= '0;
        end else if (pop) begin
            reg_write_en_w_o    <= 1'b1;
            rd_idx_w_o          <= fifo_rd_q[rd_ptr_q];
            write_back_data_w_o <= fifo_data_q[rd_ptr_q];
        end else if (take_inorder) begin
            reg_write_en_w_o    <= 1'b1;
            rd_idx_w_o          <= rd_idx_m_i;
            write_back_data_w_o <= mux_data;
        end else begin
            reg_write_en_w_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_wb_arb.sv
// Scoreboard bench for pipeline_wb_arb: queue-based reference model predicts every RF write,
// a monitor compares each cycle's write-back outputs against the predicted stream.
module tb_pipeline_wb_arb;

    localparam int XLEN       = 32;
    localparam int NUM_SRC    = 5;
    localparam int LATE_DEPTH = 4;
    localparam int CW         = $clog2(LATE_DEPTH + 1);

    logic                    clk;
    logic                    resetn;
    logic                    valid_m_i;
    logic                    reg_write_en_m_i;
    logic [4:0]              rd_idx_m_i;
    logic [NUM_SRC-1:0]      result_src_m_i;
    logic [NUM_SRC*XLEN-1:0] src_data_m_i;
    logic                    stall_m_o;
    logic                    late_valid_i;
    logic                    late_ready_o;
    logic [4:0]              late_rd_idx_i;
    logic [XLEN-1:0]         late_data_i;
    logic [CW-1:0]           late_pending_o;
    logic                    reg_write_en_w_o;
    logic [4:0]              rd_idx_w_o;
    logic [XLEN-1:0]         write_back_data_w_o;

    pipeline_wb_arb #(
        .XLEN      (XLEN),
        .NUM_SRC   (NUM_SRC),
        .LATE_DEPTH(LATE_DEPTH)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .valid_m_i          (valid_m_i),
        .reg_write_en_m_i   (reg_write_en_m_i),
        .rd_idx_m_i         (rd_idx_m_i),
        .result_src_m_i     (result_src_m_i),
        .src_data_m_i       (src_data_m_i),
        .stall_m_o          (stall_m_o),
        .late_valid_i       (late_valid_i),
        .late_ready_o       (late_ready_o),
        .late_rd_idx_i      (late_rd_idx_i),
        .late_data_i        (late_data_i),
        .late_pending_o     (late_pending_o),
        .reg_write_en_w_o   (reg_write_en_w_o),
        .rd_idx_w_o         (rd_idx_w_o),
        .write_back_data_w_o(write_back_data_w_o)
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        int              cyc;
    } wr_t;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } late_t;

    wr_t             exp_q[$];
    late_t           late_q[$];
    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    logic [4:0]      last_rd  = 5'd0;
    logic [XLEN-1:0] last_data = '0;
    logic [NUM_SRC*XLEN-1:0] src_fix;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_mux(input logic [NUM_SRC-1:0] sel,
                                                input logic [NUM_SRC*XLEN-1:0] src);
        logic [XLEN-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel[k]) r = r | src[k*XLEN +: XLEN];
        end
        return r;
    endfunction

    // Monitor: each cycle either the next predicted write appears, or the port is idle and holds.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resetn) begin
                logic exp_en;
                exp_en = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
                check("wb_en", reg_write_en_w_o, exp_en);
                if (reg_write_en_w_o && exp_en) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wb_rd", rd_idx_w_o, e.rd);
                    check("wb_data", write_back_data_w_o, e.data);
                    last_rd   = e.rd;
                    last_data = e.data;
                end else if (!reg_write_en_w_o) begin
                    check("hold_rd", rd_idx_w_o, last_rd);
                    check("hold_data", write_back_data_w_o, last_data);
                end
            end
        end
    end

    // One cycle of stimulus; the model decides the winner from the arbitration rules.
    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [NUM_SRC-1:0] sel, input logic [NUM_SRC*XLEN-1:0] src,
                         input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld);
        logic ireq;
        logic full;
        wr_t  w;
        @(negedge clk);
        valid_m_i        = v;
        reg_write_en_m_i = we;
        rd_idx_m_i       = rd;
        result_src_m_i   = sel;
        src_data_m_i     = src;
        late_valid_i     = lv;
        late_rd_idx_i    = lrd;
        late_data_i      = ld;
        #1;
        ireq = v && we && (rd != 5'd0);
        full = (late_q.size() == LATE_DEPTH);
        check("stall_m", stall_m_o, ireq && full);
        check("late_ready", late_ready_o, !full);
        check("late_pending", late_pending_o, late_q.size());
        w.cyc = cyc + 1;
        if (full || (!ireq && late_q.size() > 0)) begin
            late_t h;
            h = late_q.pop_front();
            w.rd   = h.rd;
            w.data = h.data;
            exp_q.push_back(w);
        end else if (ireq) begin
            w.rd   = rd;
            w.data = ref_mux(sel, src);
            exp_q.push_back(w);
        end
        if (lv && !full && lrd != 5'd0) begin
            late_t n;
            n.rd   = lrd;
            n.data = ld;
            late_q.push_back(n);
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, '0, '0, 1'b0, 5'd0, '0);
    endtask

    task automatic expect_wb(input string name, input logic en, input logic [4:0] rd,
                             input logic [XLEN-1:0] data);
        @(posedge clk);
        #2;
        check({name, "_en"}, reg_write_en_w_o, en);
        if (en) begin
            check({name, "_rd"}, rd_idx_w_o, rd);
            check({name, "_data"}, write_back_data_w_o, data);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_en"}, reg_write_en_w_o, 1'b0);
        check({name, "_rd"}, rd_idx_w_o, 5'd0);
        check({name, "_data"}, write_back_data_w_o, '0);
        check({name, "_pending"}, late_pending_o, '0);
        check({name, "_ready"}, late_ready_o, 1'b1);
        check({name, "_stall"}, stall_m_o, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        for (int k = 0; k < NUM_SRC; k++) src_fix[k*XLEN +: XLEN] = XLEN'((k + 1) * 'h11);
        #3;
        check_reset_state("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Mux: single, zero-hot and multi-hot selects.
        drive(1'b1, 1'b1, 5'd3, 5'b00100, src_fix, 1'b0, 5'd0, '0);
        expect_wb("mux_onehot", 1'b1, 5'd3, 32'h33);
        drive(1'b1, 1'b1, 5'd4, 5'b00000, src_fix, 1'b0, 5'd0, '0);
        expect_wb("mux_zero", 1'b1, 5'd4, 32'h0);
        drive(1'b1, 1'b1, 5'd5, 5'b00011, src_fix, 1'b0, 5'd0, '0);
        expect_wb("mux_multi", 1'b1, 5'd5, 32'h33);

        // x0 suppression on both channels.
        drive(1'b1, 1'b1, 5'd0, 5'b00001, src_fix, 1'b0, 5'd0, '0);
        expect_wb("x0_inorder", 1'b0, 5'd0, '0);
        drive(1'b0, 1'b0, 5'd0, '0, '0, 1'b1, 5'd0, 32'hBEEF);
        idle();
        check("x0_late_pending", late_pending_o, '0);

        // Late drain: visible two cycles after the push.
        drive(1'b0, 1'b0, 5'd0, '0, '0, 1'b1, 5'd7, 32'hDEAD);
        idle();
        expect_wb("late_drain", 1'b1, 5'd7, 32'hDEAD);
        idle();
        check("late_drain_pending", late_pending_o, '0);

        // Full back-pressure with ireq held, then wrap-around.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 5'd9, 5'b00010, src_fix, 1'b1, 5'(i % 31 + 1), $urandom);
        end
        repeat (6) idle();

        // Simultaneous push and pop at count 2.
        drive(1'b1, 1'b1, 5'd10, 5'b00001, src_fix, 1'b1, 5'd11, 32'hA1);
        drive(1'b1, 1'b1, 5'd10, 5'b00001, src_fix, 1'b1, 5'd12, 32'hA2);
        drive(1'b0, 1'b0, 5'd0, '0, '0, 1'b1, 5'd13, 32'hA3);
        drive(1'b1, 1'b1, 5'd10, 5'b00001, src_fix, 1'b0, 5'd0, '0);
        check("pushpop_pending", late_pending_o, CW'(2));
        repeat (4) idle();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [NUM_SRC*XLEN-1:0] src;
            for (int k = 0; k < NUM_SRC; k++) src[k*XLEN +: XLEN] = $urandom;
            drive(($urandom % 4) != 0, ($urandom % 4) != 0, 5'($urandom), 5'($urandom), src,
                  ($urandom % 3) != 0, 5'($urandom), $urandom);
        end
        repeat (6) idle();

        // Async reset mid-drain with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'd20, 5'b00001, src_fix, 1'b1, 5'(i + 21), 32'hC0 + i);
        end
        drive(1'b1, 1'b1, 5'd20, 5'b00001, src_fix, 1'b0, 5'd0, '0);
        check("prereset_pending", late_pending_o, CW'(3));
        idle();
        @(negedge clk);
        #2;
        valid_m_i        = 1'b1;
        reg_write_en_m_i = 1'b1;
        rd_idx_m_i       = 5'd6;
        resetn           = 1'b0;
        #1;
        check_reset_state("async_reset");
        exp_q.delete();
        late_q.delete();
        last_rd   = 5'd0;
        last_data = '0;
        repeat (2) @(negedge clk);
        idle_inputs();
        resetn = 1'b1;
        repeat (6) idle();

        check("exp_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic idle_inputs();
        valid_m_i        = 1'b0;
        reg_write_en_m_i = 1'b0;
        rd_idx_m_i       = 5'd0;
        result_src_m_i   = '0;
        src_data_m_i     = '0;
        late_valid_i     = 1'b0;
        late_rd_idx_i    = 5'd0;
        late_data_i      = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
